edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of level inputs (2..16).
REQ-002 SHALL have parameter CH_W, default $clog2(N_CH), width of channel index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_level  input  N_CH  per-channel level inputs.
REQ-006 SHALL have port i_ready  input  1  consumer accepts the offered event.
REQ-007 SHALL have port i_ovr_clr  input  1  clears all overrun flags.
REQ-008 SHALL have port o_valid  output  1  an event is offered.
REQ-009 SHALL have port o_ch  output  CH_W  channel index of the offered event.
REQ-010 SHALL have port o_overrun  output  N_CH  sticky per-channel overrun flags.

Function
REQ-011 SHALL, per channel, run a Moore rising-edge FSM (ZERO, EDGE, ONE): ZERO->EDGE on level 1; EDGE->ONE on 1, ->ZERO on 0; ONE->ZERO on 0; tick=1 only in EDGE.
REQ-012 SHALL set pending[c] on the clock edge ending a cycle with tick[c]=1.
REQ-013 SHALL set o_overrun[c] when tick[c]=1 while pending[c]=1 and channel c is not accepted in the same cycle.
REQ-014 SHALL, when tick[c]=1 in the same cycle channel c is accepted, leave pending[c]=1 and not flag overrun.
REQ-015 SHALL run arbiter FSM IDLE/OFFER; IDLE->OFFER when any pending bit is set, loading o_ch with the round-robin winner.
REQ-016 SHALL select the winner as the first pending channel at or after rr_ptr, wrapping from N_CH-1 to 0.
REQ-017 SHALL hold o_valid=1 and o_ch stable in OFFER until i_ready=1 (acceptance = o_valid & i_ready).
REQ-018 SHALL, on acceptance, clear pending[o_ch] and set rr_ptr=(o_ch+1) mod N_CH.
REQ-019 SHALL, on acceptance, stay in OFFER with the next winner when other channels are pending (ticks of that cycle excluded), else go to IDLE.
REQ-020 SHALL assert o_valid two clock edges after the first edge sampling i_level[c]=1 following a 0, when the arbiter is idle.
REQ-021 SHALL give i_ovr_clr priority over a simultaneous overrun set.
REQ-022 SHALL ignore i_ready when o_valid=0.

Reset
REQ-023 SHALL on reset put all edge FSMs in ZERO, arbiter in IDLE, pending=0, rr_ptr=0.
REQ-024 SHALL on reset drive o_valid=0, o_ch=0, o_overrun=0.
REQ-025 SHALL on reset mid-offer drop the event without acceptance; a level held high produces no new event after reset release.

Configuration
REQ-026 SHALL, with EDGE_ARB_SYNC_EN defined, pass each i_level through a 2-flop synchronizer (reset to 0) before the edge FSM, making REQ-020 latency four edges.
REQ-027 SHALL, without EDGE_ARB_SYNC_EN, feed i_level directly to the edge FSMs.

Structure
REQ-028 SHALL place the edge-FSM state enum (ZERO, EDGE, ONE) and the arbiter state enum (IDLE, OFFER) in package edge_arb_pkg.
REQ-029 SHALL instantiate sub-module edge_tick_fsm (clk, reset, i_level, o_tick) once per channel via generate.

Verification
REQ-030 SHALL cover: reset, i_level[2] 0->1 with i_ready=1 -> o_valid=1, o_ch=2 two edges later for one cycle, then idle.
REQ-031 SHALL cover: rising edges on ch 0,1,3 same cycle, i_ready=1 -> o_ch sequence 0,1,3 on consecutive cycles, no bubble.
REQ-032 SHALL cover: rr_ptr=2 after ch 1 accepted, then ch 0 and 3 pending -> ch 3 granted before ch 0.
REQ-033 SHALL cover: i_ready=0, two rising edges on ch 1 -> o_overrun=4'b0010, o_ch=1 held; i_ovr_clr pulse -> o_overrun=0.
REQ-034 SHALL cover: level held high 20 cycles -> exactly one event; reset asserted while o_valid=1 -> o_valid=0 next edge, no event after release.
REQ-035 SHALL cover: EDGE_ARB_SYNC_EN build -> REQ-030 stimulus yields o_valid four edges after first high sample.

Source files
------------

// File: rtl/edge_arb_pkg.sv
// rtl/edge_arb_pkg.sv - shared state encodings for the edge event arbiter
package edge_arb_pkg;

    typedef enum logic [1:0] {
        ZERO,
        EDGE,
        ONE
    } edge_state_t;

    typedef enum logic {
        IDLE,
        OFFER
    } arb_state_t;

endpackage

// File: rtl/edge_tick_fsm.sv
// rtl/edge_tick_fsm.sv - Moore rising-edge detector, one-cycle o_tick per 0->1 transition
module edge_tick_fsm
    import edge_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_level,
    output logic o_tick
);

    edge_state_t r_state;
    logic        r_armed;

    // A level already high when reset releases has no preceding 0, so it is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ZERO;
            r_armed <= 1'b0;
            o_tick  <= 1'b0;
        end else begin
            r_armed <= r_armed | ~i_level;
            o_tick  <= 1'b0;
            case (r_state)
                ZERO: begin
                    if (i_level) begin
                        if (r_armed) begin
                            r_state <= EDGE;
                            o_tick  <= 1'b1;
                        end else begin
                            r_state <= ONE;
                        end
                    end
                end
                EDGE:    r_state <= i_level ? ONE : ZERO;
                ONE:     if (!i_level) r_state <= ZERO;
                default: r_state <= ZERO;
            endcase
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - round-robin arbiter over per-channel rising edges
// EDGE_ARB_SYNC_EN adds a 2-flop synchronizer on every i_level bit.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] i_level,
    input  logic            i_ready,
    input  logic            i_ovr_clr,
    output logic            o_valid,
    output logic [CH_W-1:0] o_ch,
    output logic [N_CH-1:0] o_overrun
);
    import edge_arb_pkg::*;

    logic [N_CH-1:0] w_level;
    logic [N_CH-1:0] w_tick;
    logic [N_CH-1:0] w_acc_mask;
    logic [N_CH-1:0] w_remain;
    logic [N_CH-1:0] w_cand;
    logic            w_fsm_reset;
    logic            w_accept;

    logic [N_CH-1:0] r_pending;
    arb_state_t      r_state;
    logic [CH_W-1:0] r_rr;

    function automatic logic [CH_W-1:0] f_next(input logic [CH_W-1:0] c);
        if (int'(c) >= N_CH - 1) f_next = '0;
        else                     f_next = c + 1'b1;
    endfunction

    function automatic logic [CH_W-1:0] f_pick(input logic [N_CH-1:0] pend,
                                              input logic [CH_W-1:0] ptr);
        logic found;
        found  = 1'b0;
        f_pick = '0;
        for (int k = 0; k < N_CH; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N_CH) j = j - N_CH;
            if (!found && pend[j]) begin
                f_pick = CH_W'(j);
                found  = 1'b1;
            end
        end
    endfunction

`ifdef EDGE_ARB_SYNC_EN
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [1:0]      r_rst_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_level;
            r_sync2 <= r_sync1;
        end
    end

    // Edge FSMs stay in reset until the synchronizer has refilled with live levels.
    always_ff @(posedge clk) begin
        r_rst_pipe <= {r_rst_pipe[0], reset};
    end

    assign w_level     = r_sync2;
    assign w_fsm_reset = reset | (|r_rst_pipe);
`else
    assign w_level     = i_level;
    assign w_fsm_reset = reset;
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        edge_tick_fsm u_edge (
            .clk    (clk),
            .reset  (w_fsm_reset),
            .i_level(w_level[g]),
            .o_tick (w_tick[g])
        );
    end

    assign w_accept   = o_valid & i_ready;
    assign w_acc_mask = w_accept ? (N_CH'(1) << o_ch) : '0;
    assign w_remain   = r_pending & ~w_acc_mask;
    assign w_cand     = r_pending | w_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            o_overrun <= '0;
        end else begin
            r_pending <= w_remain | w_tick;
            o_overrun <= i_ovr_clr ? '0 : (o_overrun | (w_tick & r_pending & ~w_acc_mask));
        end
    end

    // Idle looks at this cycle's ticks too, so a fresh edge is offered without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            o_valid <= 1'b0;
            o_ch    <= '0;
            r_rr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_cand) begin
                        r_state <= OFFER;
                        o_valid <= 1'b1;
                        o_ch    <= f_pick(w_cand, r_rr);
                    end
                end
                OFFER: begin
                    if (i_ready) begin
                        r_rr <= f_next(o_ch);
                        if (|w_remain) begin
                            o_ch <= f_pick(w_remain, f_next(o_ch));
                        end else begin
                            r_state <= IDLE;
                            o_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - scoreboard bench for edge_event_arbiter (honours EDGE_ARB_SYNC_EN)
module tb_edge_event_arbiter;

`ifdef EDGE_ARB_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] i_level;
    logic       i_ready;
    logic       i_ovr_clr;
    logic       o_valid;
    logic [1:0] o_ch;
    logic [3:0] o_overrun;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    edge_event_arbiter #(.N_CH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_level  (i_level),
        .i_ready  (i_ready),
        .i_ovr_clr(i_ovr_clr),
        .o_valid  (o_valid),
        .o_ch     (o_ch),
        .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int ch, input int at);
        exp_t e;
        e.ch  = ch;
        e.cyc = at;
        q.push_back(e);
    endtask

    task automatic pulse(input logic [3:0] bits, input int hold);
        i_level = i_level | bits;
        step(hold);
        i_level = i_level & ~bits;
        step(LAT + 2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(LAT + 3);
    endtask

    // Monitor: every accepted offer must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (o_valid === 1'b1 && i_ready === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", int'(o_ch), -1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("event_ch", int'(o_ch), e.ch);
                    if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        i_level   = 4'b0000;
        i_ready   = 1'b1;
        i_ovr_clr = 1'b0;
        step(3);
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_ch", int'(o_ch), 0);
        chk("reset_overrun", int'(o_overrun), 0);
        reset = 1'b0;
        step(LAT + 3);

        // Single edge on ch2, fixed latency, then idle.
        expect_ev(2, cyc + LAT);
        pulse(4'b0100, LAT + 3);

        // Simultaneous edges on 0,1,3 from rr_ptr=0: back-to-back grants.
        do_reset();
        expect_ev(0, cyc + LAT);
        expect_ev(1, cyc + LAT + 1);
        expect_ev(3, cyc + LAT + 2);
        pulse(4'b1011, LAT + 3);

        // ch1 accepted moves rr_ptr to 2, so ch3 beats ch0.
        expect_ev(1, cyc + LAT);
        pulse(4'b0010, LAT + 3);
        expect_ev(3, cyc + LAT);
        expect_ev(0, cyc + LAT + 1);
        pulse(4'b1001, LAT + 3);

        // Stalled consumer: second ch1 edge overruns, clear drops the flag.
        i_ready = 1'b0;
        pulse(4'b0010, LAT + 1);
        pulse(4'b0010, LAT + 1);
        chk("ovr_flag", int'(o_overrun), 4'b0010);
        chk("ovr_valid_held", int'(o_valid), 1);
        chk("ovr_ch_held", int'(o_ch), 1);
        i_ovr_clr = 1'b1;
        step(1);
        i_ovr_clr = 1'b0;
        chk("ovr_cleared", int'(o_overrun), 0);
        expect_ev(1, -1);
        i_ready = 1'b1;
        step(4);

        // Level held high for 20 cycles yields one event only.
        expect_ev(2, cyc + LAT);
        pulse(4'b0100, 20);

        // Reset during an offer drops it; the still-high level is not an edge.
        i_ready = 1'b0;
        i_level = 4'b0001;
        step(LAT + 1);
        chk("pre_reset_valid", int'(o_valid), 1);
        reset = 1'b1;
        step(1);
        chk("mid_reset_valid", int'(o_valid), 0);
        chk("mid_reset_ch", int'(o_ch), 0);
        reset   = 1'b0;
        i_ready = 1'b1;
        step(12);
        chk("post_reset_valid", int'(o_valid), 0);
        i_level = 4'b0000;
        step(4);

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
